// File: rtl/lc3_dmem_responder.sv
// LC3 data-memory responder: synchronous word array with programmable wait states and a one-cycle ready pulse.
// Optional macro DMEM_RANGE_CHK_EN flags and suppresses accesses whose dmem_addr[15:ADDR_W] bits are nonzero.
module lc3_dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dmem_en,
  input  logic        dmem_rd,
  input  logic [15:0] dmem_addr,
  input  logic [15:0] dmem_din,
  output logic [15:0] dmem_dout,
  output logic        dmem_ready,
  output logic        dmem_busy,
  output logic        dmem_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                rd_q, rd_d;
  logic [15:0]         addr_q, addr_d;
  logic [15:0]         din_q, din_d;
  logic [15:0]         dout_q, dout_d;
  logic [15:0]         mem [2**ADDR_W];

  logic                req_oor;
  logic                resp_oor;
  logic                load_rd;
  logic                rd_oor;
  logic [ADDR_W-1:0]   rd_idx;

`ifdef DMEM_RANGE_CHK_EN
  assign req_oor  = (dmem_addr[15:ADDR_W] != '0);
  assign resp_oor = (addr_q[15:ADDR_W] != '0);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^{dmem_addr[15:ADDR_W], addr_q[15:ADDR_W]};
  assign req_oor  = 1'b0;
  assign resp_oor = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    rd_idx  = addr_q[ADDR_W-1:0];
    rd_oor  = resp_oor;
    load_rd = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (dmem_en) begin
          rd_d   = dmem_rd;
          addr_d = dmem_addr;
          din_d  = dmem_din;
          if (WAIT_STATES == 0) begin
            // No wait states: the read data is fetched on the accepting edge itself.
            state_d = S_RESP;
            cnt_d   = '0;
            rd_idx  = dmem_addr[ADDR_W-1:0];
            rd_oor  = req_oor;
            load_rd = dmem_rd;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          cnt_d   = '0;
          load_rd = rd_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (load_rd) dout_d = rd_oor ? 16'h0000 : mem[rd_idx];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
    end
  end

  // Array contents survive reset; an aborted request never reaches RESP, so it never writes.
  always_ff @(posedge clock) begin
    if (state_q == S_RESP && !rd_q && !resp_oor) mem[addr_q[ADDR_W-1:0]] <= din_q;
  end

  assign dmem_dout  = dout_q;
  assign dmem_ready = (state_q == S_RESP);
  assign dmem_busy  = (state_q != S_IDLE);
  assign dmem_err   = (state_q == S_RESP) && resp_oor;

endmodule

// File: tb/tb_lc3_dmem_responder.sv
// Self-checking bench: two responders (2 and 0 wait states) against an array-based reference model.
module tb_lc3_dmem_responder;

  localparam int WS_A = 2;
  localparam int WS_B = 0;
`ifdef DMEM_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        en_a = 1'b0, rd_a = 1'b0;
  logic [15:0] addr_a = '0, din_a = '0;
  logic [15:0] dout_a;
  logic        ready_a, busy_a, err_a;

  logic        en_b = 1'b0, rd_b = 1'b0;
  logic [15:0] addr_b = '0, din_b = '0;
  logic [15:0] dout_b;
  logic        ready_b, busy_b, err_b;

  always #5 clock = ~clock;

  lc3_dmem_responder #(.ADDR_W(8), .WAIT_STATES(WS_A)) dut_a (
    .clock(clock), .reset(reset), .dmem_en(en_a), .dmem_rd(rd_a),
    .dmem_addr(addr_a), .dmem_din(din_a), .dmem_dout(dout_a),
    .dmem_ready(ready_a), .dmem_busy(busy_a), .dmem_err(err_a)
  );

  lc3_dmem_responder #(.ADDR_W(8), .WAIT_STATES(WS_B)) dut_b (
    .clock(clock), .reset(reset), .dmem_en(en_b), .dmem_rd(rd_b),
    .dmem_addr(addr_b), .dmem_din(din_b), .dmem_dout(dout_b),
    .dmem_ready(ready_b), .dmem_busy(busy_b), .dmem_err(err_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] mdl_mem  [2][256];
  logic [15:0] mdl_dout [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int s, input logic en, input logic rd,
                       input logic [15:0] a, input logic [15:0] d);
    if (s == 0) begin
      en_a = en; rd_a = rd; addr_a = a; din_a = d;
    end else begin
      en_b = en; rd_b = rd; addr_b = a; din_b = d;
    end
  endtask

  function automatic logic rdy_of(input int s);
    return (s == 0) ? ready_a : ready_b;
  endfunction
  function automatic logic busy_of(input int s);
    return (s == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic err_of(input int s);
    return (s == 0) ? err_a : err_b;
  endfunction
  function automatic logic [15:0] dout_of(input int s);
    return (s == 0) ? dout_a : dout_b;
  endfunction
  function automatic int ws_of(input int s);
    return (s == 0) ? WS_A : WS_B;
  endfunction

  // One full request on responder s, with bus noise after acceptance, checked against the model.
  task automatic req(input int s, input logic rd, input logic [15:0] a, input logic [15:0] d);
    int         edges;
    bit         oor;
    logic [7:0] idx;
    oor = RANGE_CHK && (a[15:8] != 8'h00);
    idx = a[7:0];
    @(negedge clock);
    drive(s, 1'b1, rd, a, d);
    @(posedge clock);
    edges = 1;
    @(negedge clock);
    drive(s, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
    check("busy_after_accept", 32'(busy_of(s)), 32'd1);
    while (!rdy_of(s) && edges < 40) begin
      drive(s, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      @(negedge clock);
      edges++;
    end
    drive(s, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check("ready_seen", 32'(rdy_of(s)), 32'd1);
    check("latency_edges", 32'(edges), 32'(ws_of(s) + 1));
    check("err_flag", 32'(err_of(s)), 32'(oor));
    if (rd) mdl_dout[s] = oor ? 16'h0000 : mdl_mem[s][idx];
    else if (!oor) mdl_mem[s][idx] = d;
    check(rd ? "read_data" : "dout_after_write", 32'(dout_of(s)), 32'(mdl_dout[s]));
    @(negedge clock);
    check("ready_one_cycle", 32'(rdy_of(s)), 32'd0);
    check("idle_after_resp", 32'(busy_of(s)), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int         acc;
    int         cnt;
    int         phase;
    logic [15:0] prior;
    logic [15:0] ra;

    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_dout_a", 32'(dout_a), 32'h0);
    check("rst_ready_a", 32'(ready_a), 32'h0);
    check("rst_busy_a", 32'(busy_a), 32'h0);
    check("rst_err_a", 32'(err_a), 32'h0);
    check("rst_dout_b", 32'(dout_b), 32'h0);
    reset = 1'b1;
    mdl_dout[0] = 16'h0000;
    mdl_dout[1] = 16'h0000;

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) req(s, 1'b0, 16'(i), 16'($urandom));

    req(0, 1'b0, 16'h0010, 16'hA5A5);
    req(0, 1'b1, 16'h0010, 16'h0000);
    check("raw_a5a5", 32'(dout_a), 32'h0000A5A5);

    // en held high for 8 cycles: accepts every WS_A+2 cycles, never queued.
    acc = 0;
    @(negedge clock);
    drive(0, 1'b1, 1'b1, 16'h0010, 16'h0000);
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      phase = c % (WS_A + 2);
      check("tput_busy", 32'(busy_a), 32'(phase < WS_A + 1));
      check("tput_ready", 32'(ready_a), 32'(phase == WS_A));
      if (ready_a) acc++;
    end
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check("tput_accepts", 32'(acc), 32'd2);
    mdl_dout[0] = mdl_mem[0][8'h10];
    check("tput_dout", 32'(dout_a), 32'(mdl_dout[0]));

    prior = mdl_mem[0][8'h05];
    req(0, 1'b0, 16'h0105, 16'h1234);
    req(0, 1'b1, 16'h0005, 16'h0000);
    check("alias_read", 32'(dout_a), RANGE_CHK ? 32'(prior) : 32'h00001234);
    req(0, 1'b1, 16'h0105, 16'h0000);

    req(0, 1'b0, 16'h0020, 16'h1111);
    @(negedge clock);
    drive(0, 1'b1, 1'b0, 16'h0020, 16'hBEEF);
    @(negedge clock);
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check("abort_in_wait", 32'(busy_a), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_rst_dout", 32'(dout_a), 32'h0);
    check("abort_rst_ready", 32'(ready_a), 32'h0);
    check("abort_rst_busy", 32'(busy_a), 32'h0);
    check("abort_rst_dout_b", 32'(dout_b), 32'h0);
    mdl_dout[0] = 16'h0000;
    mdl_dout[1] = 16'h0000;
    #2 reset = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clock);
      if (ready_a) cnt++;
    end
    check("abort_no_ready", 32'(cnt), 32'd0);
    req(0, 1'b1, 16'h0020, 16'h0000);
    check("abort_read", 32'(dout_a), 32'h00001111);

    for (int k = 0; k < 80; k++) begin
      ra = 16'($urandom);
      if ($urandom_range(0, 1) == 1) ra[15:8] = 8'h00;
      req(int'($urandom_range(0, 1)), 1'($urandom), ra, 16'($urandom));
    end

    req(1, 1'b0, 16'h0033, 16'h7E57);
    req(1, 1'b1, 16'h0033, 16'h0000);
    check("ws0_read", 32'(dout_b), 32'h00007E57);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
